// File: rtl/vending_sequencer.sv
// vending_sequencer -- control FSM for the food vending machine.
//
// Collects coin credit from the c (R$0.50 = 1 unit) and u (R$1.00 = 2 units)
// buttons. Shows that credit on a 10-LED thermometer. Moves a 4-entry product
// cursor with cima/baixo. On enter it charges the selected product and holds
// that product's dispense output for DISPENSE_CYCLES cycles.
//
// Optional build macro: TROCO_EN
//   When defined, the remaining credit is returned as change when a dispense
//   completes. This adds the troco / troco_valid ports.
//
// Ports:
//   clock        in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high
//   c, u         in   1   coin buttons (level, already debounced)
//   cima, baixo  in   1   cursor up / down buttons (level)
//   enter        in   1   purchase button (level)
//   led          out  10  credit thermometer, led[i] = (credito > i)
//   sel          out  2   cursor: 0 pizza, 1 burguer, 2 torta, 3 soda
//   credito      out  4   current credit in units
//   pizza, burguer, torta, soda  out 1  dispense outputs, products 0..3
//   sucesso      out  1   1-cycle pulse, accepted operation
//   falha        out  1   1-cycle pulse, rejected operation
//   troco        out  4   (TROCO_EN) change returned at dispense completion
//   troco_valid  out  1   (TROCO_EN) 1-cycle pulse alongside the final sucesso
module vending_sequencer #(
   parameter int PRICE_PIZZA     = 6,
   parameter int PRICE_BURGUER   = 5,
   parameter int PRICE_TORTA     = 4,
   parameter int PRICE_SODA      = 2,
   parameter int MAX_CREDIT      = 10,
   parameter int DISPENSE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       c,
   input  logic       u,
   input  logic       cima,
   input  logic       baixo,
   input  logic       enter,
   output logic [9:0] led,
   output logic [1:0] sel,
   output logic [3:0] credito,
   output logic       pizza,
   output logic       burguer,
   output logic       torta,
   output logic       soda,
   output logic       sucesso,
   output logic       falha
`ifdef TROCO_EN
   ,
   output logic [3:0] troco,
   output logic       troco_valid
`endif
);

   localparam int CW = $clog2(DISPENSE_CYCLES + 1);

   // Bit positions inside the button history vectors.
   localparam int BTN_C     = 0;
   localparam int BTN_U     = 1;
   localparam int BTN_CIMA  = 2;
   localparam int BTN_BAIXO = 3;
   localparam int BTN_ENTER = 4;

   typedef enum logic {
      IDLE,
      DISPENSE
   } state_t;

   state_t          state_reg, state_next;
   logic [4:0]      btn_cur_reg, btn_prev_reg;
   logic [4:0]      evt;
   logic [3:0]      credito_reg, credito_next;
   logic [1:0]      sel_reg, sel_next, sel_step;
   logic [3:0]      dispense_reg, dispense_next;
   logic [CW-1:0]   count_reg, count_next;
   logic            sucesso_reg, sucesso_next;
   logic            falha_reg, falha_next;
   logic [9:0]      led_reg, led_next;
   logic [4:0]      add_units;
   logic [4:0]      credit_sum;
   logic [3:0]      price_sel;
`ifdef TROCO_EN
   logic [3:0]      troco_reg, troco_next;
   logic            troco_valid_reg, troco_valid_next;
`endif

   // A button only produces an event on its rising edge.
   assign evt = btn_cur_reg & ~btn_prev_reg;

   always_comb begin
      price_sel = 4'(PRICE_PIZZA);
      case (sel_reg)
         2'd0:    price_sel = 4'(PRICE_PIZZA);
         2'd1:    price_sel = 4'(PRICE_BURGUER);
         2'd2:    price_sel = 4'(PRICE_TORTA);
         default: price_sel = 4'(PRICE_SODA);
      endcase
   end

   // Coin value of this cycle's events. Both coins together are worth 3 units.
   assign add_units  = {3'd0, evt[BTN_U], evt[BTN_C]};
   assign credit_sum = {1'b0, credito_reg} + add_units;

   // Cursor movement. Opposite presses in the same cycle cancel each other out.
   always_comb begin
      sel_step = sel_reg;
      if (evt[BTN_CIMA] && !evt[BTN_BAIXO]) begin
         sel_step = sel_reg - 2'd1;
      end else if (evt[BTN_BAIXO] && !evt[BTN_CIMA]) begin
         sel_step = sel_reg + 2'd1;
      end
   end

   always_comb begin
      state_next    = state_reg;
      credito_next  = credito_reg;
      sel_next      = sel_reg;
      dispense_next = dispense_reg;
      count_next    = count_reg;
      sucesso_next  = 1'b0;
      falha_next    = 1'b0;
`ifdef TROCO_EN
      troco_next       = troco_reg;
      troco_valid_next = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            // The cursor moves after the price check, so the check uses the
            // old sel even when enter and a cursor button land together.
            sel_next = sel_step;
            if (evt[BTN_ENTER]) begin
               // Enter wins. Coin events in the same cycle are dropped silently.
               if (credito_reg >= price_sel) begin
                  credito_next  = credito_reg - price_sel;
                  dispense_next = 4'b0001 << sel_reg;
                  count_next    = CW'(DISPENSE_CYCLES - 1);
                  state_next    = DISPENSE;
               end else begin
                  falha_next = 1'b1;
               end
            end else if (add_units != 5'd0) begin
               // An addition that would overflow is rejected as a whole.
               if (credit_sum > 5'(MAX_CREDIT)) begin
                  falha_next = 1'b1;
               end else begin
                  credito_next = credit_sum[3:0];
                  sucesso_next = 1'b1;
               end
            end
         end
         DISPENSE: begin
            // Button events are ignored here. Edge history keeps tracking
            // regardless, so a button held through DISPENSE stays consumed.
            if (count_reg == '0) begin
               dispense_next = 4'b0000;
               sucesso_next  = 1'b1;
               state_next    = IDLE;
`ifdef TROCO_EN
               troco_next       = credito_reg;
               troco_valid_next = 1'b1;
               credito_next     = 4'd0;
`endif
            end else begin
               count_next = count_reg - CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The thermometer is computed from the next credit value so that it
   // updates on the same edge as credito.
   genvar gi;
   generate
      for (gi = 0; gi < 10; gi++) begin : g_led
         assign led_next[gi] = (credito_next > 4'(gi));
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         btn_cur_reg  <= 5'd0;
         btn_prev_reg <= 5'd0;
         credito_reg  <= 4'd0;
         sel_reg      <= 2'd0;
         dispense_reg <= 4'd0;
         count_reg    <= '0;
         sucesso_reg  <= 1'b0;
         falha_reg    <= 1'b0;
         led_reg      <= 10'd0;
`ifdef TROCO_EN
         troco_reg       <= 4'd0;
         troco_valid_reg <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         btn_cur_reg  <= {enter, baixo, cima, u, c};
         btn_prev_reg <= btn_cur_reg;
         credito_reg  <= credito_next;
         sel_reg      <= sel_next;
         dispense_reg <= dispense_next;
         count_reg    <= count_next;
         sucesso_reg  <= sucesso_next;
         falha_reg    <= falha_next;
         led_reg      <= led_next;
`ifdef TROCO_EN
         troco_reg       <= troco_next;
         troco_valid_reg <= troco_valid_next;
`endif
      end
   end

   assign led     = led_reg;
   assign sel     = sel_reg;
   assign credito = credito_reg;
   assign pizza   = dispense_reg[0];
   assign burguer = dispense_reg[1];
   assign torta   = dispense_reg[2];
   assign soda    = dispense_reg[3];
   assign sucesso = sucesso_reg;
   assign falha   = falha_reg;
`ifdef TROCO_EN
   assign troco       = troco_reg;
   assign troco_valid = troco_valid_reg;
`endif

endmodule

// File: tb/tb_vending_sequencer.sv
// Testbench for vending_sequencer. It runs directed scenarios and then a
// randomized sequence of button presses. All of them are checked against a
// transaction-level model of credit, cursor and purchase outcome.
module tb_vending_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       c = 1'b0, u = 1'b0, cima = 1'b0, baixo = 1'b0, enter = 1'b0;
   logic [9:0] led;
   logic [1:0] sel;
   logic [3:0] credito;
   logic       pizza, burguer, torta, soda, sucesso, falha;
`ifdef TROCO_EN
   logic [3:0] troco;
   logic       troco_valid;
`endif

   vending_sequencer dut (
      .clock   (clock),
      .reset   (reset),
      .c       (c),
      .u       (u),
      .cima    (cima),
      .baixo   (baixo),
      .enter   (enter),
      .led     (led),
      .sel     (sel),
      .credito (credito),
      .pizza   (pizza),
      .burguer (burguer),
      .torta   (torta),
      .soda    (soda),
      .sucesso (sucesso),
      .falha   (falha)
`ifdef TROCO_EN
      ,
      .troco       (troco),
      .troco_valid (troco_valid)
`endif
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   int m_credit = 0;
   int m_sel    = 0;
   int prices[4] = '{6, 5, 4, 2};
   localparam int MAXC = 10;
   localparam int DCYC = 4;

   // Button vector layout: {enter, baixo, cima, u, c}
   localparam logic [4:0] B_C     = 5'b00001;
   localparam logic [4:0] B_U     = 5'b00010;
   localparam logic [4:0] B_CIMA  = 5'b00100;
   localparam logic [4:0] B_BAIXO = 5'b01000;
   localparam logic [4:0] B_ENTER = 5'b10000;

   logic s_obs, f_obs;

   function automatic logic [9:0] led_of(input int cr);
      logic [10:0] t;
      t = (11'd1 << cr) - 11'd1;
      return t[9:0];
   endfunction

   function automatic logic [3:0] outs();
      return {soda, torta, burguer, pizza};
   endfunction

   task automatic drive(input logic [4:0] b);
      {enter, baixo, cima, u, c} = b;
   endtask

   // Hold a button pattern for one cycle, then release it. Sample the outputs
   // once the press has taken effect (one edge after it was captured).
   task automatic press(input logic [4:0] b, output logic s, output logic f);
      @(negedge clock);
      drive(b);
      @(negedge clock);
      drive(5'b0);
      @(negedge clock);
      s = sucesso;
      f = falha;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      drive(5'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      m_credit = 0;
      m_sel    = 0;
   endtask

   // Load credit with u presses. The outcome is not checked here.
   task automatic load_u(input int n);
      for (int i = 0; i < n; i++) begin
         press(B_U, s_obs, f_obs);
         m_credit += 2;
      end
   endtask

   // Follow a dispense that has just started. Checks the one-hot output, the
   // exact duration and the completion pulse(s).
   task automatic run_dispense(input int prod, input string tag);
      int cnt;
      logic [3:0] exp_o;
      exp_o = 4'b0001 << prod;
      cnt = 0;
      while (outs() != 4'b0 && cnt < 20) begin
         n_checks++;
         if (outs() !== exp_o || sucesso !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dispense_out: got outs=%b sucesso=%b want outs=%b sucesso=0", tag, outs(), sucesso, exp_o);
         end
         cnt++;
         @(negedge clock);
      end
      n_checks++;
      if (cnt != DCYC) begin
         n_fail++;
         $display("FAIL %s dispense_len: got %0d want %0d", tag, cnt, DCYC);
      end
      n_checks++;
      if (sucesso !== 1'b1 || falha !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_pulse: got sucesso=%b falha=%b want 1/0", tag, sucesso, falha);
      end
`ifdef TROCO_EN
      n_checks++;
      if (troco_valid !== 1'b1 || troco !== 4'(m_credit)) begin
         n_fail++;
         $display("FAIL %s troco: got valid=%b troco=%0d want 1/%0d", tag, troco_valid, troco, m_credit);
      end
      m_credit = 0;
`endif
      n_checks++;
      if (credito !== 4'(m_credit) || led !== led_of(m_credit)) begin
         n_fail++;
         $display("FAIL %s done_credit: got %0d led=%b want %0d", tag, credito, led, m_credit);
      end
      @(negedge clock);
      n_checks++;
      if (sucesso !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_pulse_len: sucesso still %b want 0", tag, sucesso);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (credito !== 4'd0 || sel !== 2'd0 || led !== 10'd0 || outs() !== 4'd0 ||
          sucesso !== 1'b0 || falha !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got credito=%0d sel=%0d led=%b outs=%b s=%b f=%b want all 0",
                  credito, sel, led, outs(), sucesso, falha);
      end
      $display("reset: credito=%0d sel=%0d led=%b", credito, sel, led);
   endtask

   task automatic test_coin_fill();
      do_reset();
      for (int n = 1; n <= 10; n++) begin
         press(B_C, s_obs, f_obs);
         m_credit = n;
         n_checks++;
         if (s_obs !== 1'b1 || f_obs !== 1'b0 || credito !== 4'(n) || led[n-1] !== 1'b1 || led !== led_of(n)) begin
            n_fail++;
            $display("FAIL coin_fill_%0d: got s=%b f=%b credito=%0d led=%b want 1/0/%0d/%b",
                     n, s_obs, f_obs, credito, led, n, led_of(n));
         end
         $display("coin c #%0d: credito=%0d led=%b", n, credito, led);
      end
      press(B_C, s_obs, f_obs);
      n_checks++;
      if (s_obs !== 1'b0 || f_obs !== 1'b1 || credito !== 4'd10) begin
         n_fail++;
         $display("FAIL coin_overflow: got s=%b f=%b credito=%0d want 0/1/10", s_obs, f_obs, credito);
      end
      $display("coin c #11: falha=%b credito=%0d", f_obs, credito);
   endtask

   task automatic test_overflow_and_combo();
      do_reset();
      load_u(4);
      press(B_C, s_obs, f_obs);
      press(B_U, s_obs, f_obs);
      n_checks++;
      if (s_obs !== 1'b0 || f_obs !== 1'b1 || credito !== 4'd9) begin
         n_fail++;
         $display("FAIL u_overflow: got s=%b f=%b credito=%0d want 0/1/9", s_obs, f_obs, credito);
      end
      $display("u at 9: falha=%b credito=%0d", f_obs, credito);
      do_reset();
      press(B_C | B_U, s_obs, f_obs);
      n_checks++;
      if (s_obs !== 1'b1 || credito !== 4'd3 || led !== 10'b0000000111) begin
         n_fail++;
         $display("FAIL c_plus_u: got s=%b credito=%0d led=%b want 1/3/0000000111", s_obs, credito, led);
      end
      $display("c+u: credito=%0d led=%b", credito, led);
   endtask

   task automatic test_cursor();
      int exp_seq[3] = '{3, 2, 1};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         press(B_CIMA, s_obs, f_obs);
         n_checks++;
         if (sel !== 2'(exp_seq[i])) begin
            n_fail++;
            $display("FAIL cursor_cima_%0d: got %0d want %0d", i, sel, exp_seq[i]);
         end
         $display("cima: sel=%0d", sel);
      end
      press(B_BAIXO, s_obs, f_obs);
      press(B_BAIXO, s_obs, f_obs);
      press(B_BAIXO, s_obs, f_obs);
      n_checks++;
      if (sel !== 2'd0) begin
         n_fail++;
         $display("FAIL cursor_wrap_up: got %0d want 0", sel);
      end
      $display("baixo from 3: sel=%0d", sel);
      press(B_BAIXO, s_obs, f_obs);
      press(B_CIMA | B_BAIXO, s_obs, f_obs);
      n_checks++;
      if (sel !== 2'd1 || s_obs !== 1'b0 || f_obs !== 1'b0) begin
         n_fail++;
         $display("FAIL cursor_both: got sel=%0d s=%b f=%b want 1/0/0", sel, s_obs, f_obs);
      end
      $display("cima+baixo: sel=%0d", sel);
   endtask

   task automatic test_purchase();
      do_reset();
      load_u(5);
      press(B_BAIXO, s_obs, f_obs);
      m_sel = 1;
      press(B_ENTER, s_obs, f_obs);
      m_credit = 5;
      n_checks++;
      if (s_obs !== 1'b0 || f_obs !== 1'b0 || credito !== 4'd5 || burguer !== 1'b1) begin
         n_fail++;
         $display("FAIL purchase_start: got s=%b f=%b credito=%0d burguer=%b want 0/0/5/1",
                  s_obs, f_obs, credito, burguer);
      end
      $display("buy burguer: credito=%0d", credito);
      run_dispense(1, "purchase");
   endtask

   task automatic test_insufficient();
      do_reset();
      press(B_C | B_U, s_obs, f_obs);
      press(B_ENTER, s_obs, f_obs);
      n_checks++;
      if (s_obs !== 1'b0 || f_obs !== 1'b1 || credito !== 4'd3 || outs() !== 4'd0) begin
         n_fail++;
         $display("FAIL insufficient: got s=%b f=%b credito=%0d outs=%b want 0/1/3/0000",
                  s_obs, f_obs, credito, outs());
      end
      $display("pizza with 3: falha=%b credito=%0d", f_obs, credito);
   endtask

   task automatic test_enter_held();
      int rises;
      logic any_prev, any_now;
      do_reset();
      load_u(5);
      press(B_CIMA, s_obs, f_obs);
      m_sel = 3;
      @(negedge clock);
      enter = 1'b1;
      rises = 0;
      any_prev = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         if (i == 9) enter = 1'b0;
         any_now = |outs();
         if (any_now && !any_prev) rises++;
         any_prev = any_now;
      end
      m_credit = 10 - prices[3];
`ifdef TROCO_EN
      m_credit = 0;
`endif
      n_checks++;
      if (rises != 1 || credito !== 4'(m_credit)) begin
         n_fail++;
         $display("FAIL enter_held: got dispenses=%0d credito=%0d want 1/%0d", rises, credito, m_credit);
      end
      $display("enter held: dispenses=%0d credito=%0d", rises, credito);
   endtask

   task automatic test_reset_mid_dispense();
      do_reset();
      load_u(5);
      press(B_ENTER, s_obs, f_obs);
      n_checks++;
      if (pizza !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_start: got pizza=%b want 1", pizza);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if (outs() !== 4'd0 || credito !== 4'd0 || led !== 10'd0 || sucesso !== 1'b0 || falha !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got outs=%b credito=%0d led=%b s=%b f=%b want all 0",
                  outs(), credito, led, sucesso, falha);
      end
      $display("reset mid-dispense: outs=%b credito=%0d", outs(), credito);
      reset = 1'b0;
      m_credit = 0;
      m_sel = 0;
   endtask

   task automatic test_random();
      logic [4:0] b;
      int r, add, buy;
      logic exp_s, exp_f;
      do_reset();
      for (int t = 0; t < 120; t++) begin
         r = $urandom_range(0, 11);
         case (r)
            0, 1, 2: b = B_C;
            3, 4:    b = B_U;
            5:       b = B_C | B_U;
            6:       b = B_CIMA;
            7:       b = B_BAIXO;
            8:       b = B_CIMA | B_BAIXO;
            default: b = B_ENTER | 5'($urandom_range(0, 15));
         endcase
         exp_s = 1'b0;
         exp_f = 1'b0;
         buy = -1;
         if (b[4]) begin
            if (m_credit >= prices[m_sel]) begin
               m_credit -= prices[m_sel];
               buy = m_sel;
            end else begin
               exp_f = 1'b1;
            end
         end else if (b[0] || b[1]) begin
            add = int'(b[0]) + 2 * int'(b[1]);
            if (m_credit + add > MAXC) exp_f = 1'b1;
            else begin
               m_credit += add;
               exp_s = 1'b1;
            end
         end
         m_sel = (m_sel + int'(b[3]) - int'(b[2]) + 4) % 4;
         press(b, s_obs, f_obs);
         n_checks++;
         if (s_obs !== exp_s || f_obs !== exp_f || credito !== 4'(m_credit) ||
             sel !== 2'(m_sel) || led !== led_of(m_credit) ||
             outs() !== ((buy >= 0) ? (4'b0001 << buy) : 4'b0000)) begin
            n_fail++;
            $display("FAIL random_%0d btn=%b: got s=%b f=%b cr=%0d sel=%0d outs=%b want s=%b f=%b cr=%0d sel=%0d buy=%0d",
                     t, b, s_obs, f_obs, credito, sel, outs(), exp_s, exp_f, m_credit, m_sel, buy);
         end
         $display("random %0d btn=%b: credito=%0d sel=%0d s=%b f=%b buy=%0d", t, b, credito, sel, s_obs, f_obs, buy);
         if (buy >= 0) run_dispense(buy, "random");
      end
   endtask

   initial begin
      test_reset();
      test_coin_fill();
      test_overflow_and_combo();
      test_cursor();
      test_purchase();
      test_insufficient();
      test_enter_held();
      test_reset_mid_dispense();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
